// File: rtl/reset_sequencer.sv
// Reset sequencer: releases memory, vector unit and scalar core in a fixed,
// counted order, with a soft-reset path that re-sequences only vpu and core.
module reset_sequencer #(
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 4,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic nrst,
  input  logic mem_init_done,
  input  logic soft_rst_req,
  output logic mem_nrst,
  output logic vpu_nrst,
  output logic core_nrst,
  output logic rst_done,
  output logic init_timeout
);

  localparam int MAX_AB = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_P  = (MAX_AB > INIT_TIMEOUT) ? MAX_AB : INIT_TIMEOUT;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);

  localparam int N_STAGES = 3;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_MEM  = 3'd1,
    ST_GAP       = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_HOLD = 3'd4
  } state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Stage vector, index 0 = memory, 1 = vector unit, 2 = core.
  logic [N_STAGES-1:0] stage_reg;
  logic [N_STAGES-1:0] stage_req;
  logic [N_STAGES-1:0] stage_next;
  logic mem_next, vpu_next, core_next;
  logic done_reg, done_next;
  logic timeout_reg, timeout_next;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg   <= ST_HOLD;
      cnt_reg     <= '0;
      stage_reg   <= '0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      stage_reg   <= stage_next;
      done_reg    <= done_next & stage_next[N_STAGES-1];
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin : next_state_logic
    state_next = state_reg;
    case (state_reg)
      ST_HOLD:      if (cnt_reg == HOLD_LAST) state_next = ST_WAIT_MEM;
      ST_WAIT_MEM:  if (mem_init_done || (cnt_reg == INIT_LAST)) state_next = ST_GAP;
      ST_GAP:       if (cnt_reg == GAP_LAST) state_next = ST_RUN;
      ST_RUN:       if (soft_rst_req) state_next = ST_SOFT_HOLD;
      ST_SOFT_HOLD: if (cnt_reg == HOLD_LAST) state_next = ST_GAP;
      default:      state_next = ST_HOLD;
    endcase
    cnt_next = (state_next != state_reg) ? '0 : cnt_reg + CNT_W'(1);
  end

  always_comb begin : output_logic
    mem_next     = stage_reg[0];
    vpu_next     = stage_reg[1];
    core_next    = stage_reg[2];
    done_next    = done_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_HOLD: begin
        if (cnt_reg == HOLD_LAST) mem_next = 1'b1;
      end
      ST_WAIT_MEM: begin
        // A done seen on the timeout edge wins, so the flag stays clear.
        if (mem_init_done) begin
          vpu_next = 1'b1;
        end else if (cnt_reg == INIT_LAST) begin
          vpu_next     = 1'b1;
          timeout_next = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          core_next = 1'b1;
          done_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (soft_rst_req) begin
          vpu_next  = 1'b0;
          core_next = 1'b0;
          done_next = 1'b0;
        end
      end
      ST_SOFT_HOLD: begin
        if (cnt_reg == HOLD_LAST) vpu_next = 1'b1;
      end
      default: begin
        mem_next  = 1'b0;
        vpu_next  = 1'b0;
        core_next = 1'b0;
        done_next = 1'b0;
      end
    endcase
  end

  assign stage_req = {core_next, vpu_next, mem_next};

  // Each stage may only be released once every earlier stage is released.
  assign stage_next[0] = stage_req[0];
  generate
    for (genvar gi = 1; gi < N_STAGES; gi++) begin : g_order
      assign stage_next[gi] = stage_req[gi] & stage_next[gi-1];
    end
  endgenerate

  assign mem_nrst     = stage_reg[0];
  assign vpu_nrst     = stage_reg[1];
  assign core_nrst    = stage_reg[2];
  assign rst_done     = done_reg;
  assign init_timeout = timeout_reg;

endmodule
